uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  Parametrised UART receiver. Successor to the fixed 8N1 receiver: configurable data width,
//  parity mode and stop-bit count, with parity/framing-error reporting, false-start rejection
//  and break handling. Sits between the raw serial line and the byte consumer; pairs with the TX.
// PARAMETERS
//  CLKS_PER_BIT  87  clocks per bit (10 MHz / 115200); legal >= 8
//  DATA_BITS     8   data bits per frame, 5..9, LSB first
//  PARITY        0   0 = none, 1 = odd, 2 = even
//  STOP_BITS     1   1 or 2
// PORTS
//  i_Clock       in   1          system clock
//  i_Reset       in   1          synchronous, active-high reset
//  i_RX_Serial   in   1          async serial line, idle high
//  o_RX_DV       out  1          one-cycle pulse: frame complete, outputs below valid
//  o_RX_Byte     out  DATA_BITS  received data, held until next o_RX_DV
//  o_Parity_Err  out  1          parity mismatch on the frame flagged by o_RX_DV (0 if PARITY=0)
//  o_Frame_Err   out  1          a stop bit sampled low on the frame flagged by o_RX_DV
//  o_RX_Active   out  1          high from valid start detection until return to IDLE
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset values: o_RX_DV=0, o_RX_Byte=0, o_Parity_Err=0, o_Frame_Err=0, o_RX_Active=0.
//    Synchroniser flops reset to 1. FSM goes to IDLE; bit and clock counters go to 0.
//  - i_RX_Serial passes through a 2-FF synchroniser. All "line" references below mean the
//    synchronised value.
//  - Clock counter: width $clog2(CLKS_PER_BIT). Bit index: width $clog2(DATA_BITS).
//  - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
//  - IDLE: when line=0, go to START with counter=0.
//  - START: at count (CLKS_PER_BIT-1)/2 (mid-bit), sample the line.
//      - Line=1: false start. Return to IDLE. No DV, no error flag.
//      - Line=0: set o_RX_Active=1, clear counter, go to DATA.
//  - DATA: each sample taken at count CLKS_PER_BIT-1, then counter clears.
//      - Bit i is written to shift position i (LSB first).
//      - After bit DATA_BITS-1, go to PARITY if PARITY!=0, else to STOP.
//  - PARITY: one sample. Expected bit is XOR of data (even) or its complement (odd).
//    A mismatch latches a pending parity error.
//  - STOP: STOP_BITS samples. Any stop sample = 0 latches a pending framing error.
//    After the last stop sample, on the next clock:
//      - o_RX_DV=1 for exactly one cycle.
//      - o_RX_Byte, o_Parity_Err and o_Frame_Err update in that same cycle and hold until
//        the next DV.
//      - Next state: IDLE if line=1; BREAK_WAIT if line=0.
//  - Break: all-zero data plus a low stop bit is reported once as o_Frame_Err=1 with
//    o_RX_Byte=0. BREAK_WAIT stays until line=1, then goes to IDLE (no repeated DVs).
//  - o_RX_Active drops in the cycle DV asserts.
//  - Latency: DV asserts 1 clock after the final stop-bit mid-sample, i.e. about
//    2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS + parity + STOP_BITS)*CLKS_PER_BIT + 1 clocks
//    after the line falling edge.
//  - Back-to-back frames: a start edge in the cycle after DV is accepted with no dead time.
//  - Reset asserted mid-frame aborts it: no DV, all outputs return to reset values.
//  - Errors never suppress DV: data is always delivered with its flags.
// STRUCTURE
//  - Shared package uart_pkg: parity encodings (PAR_NONE/PAR_ODD/PAR_EVEN) and the RX state
//    localparams. The TX successor reuses both.
//  - One sub-module: uart_sync2, a 2-FF synchroniser with reset value 1 (reusable for any
//    async input).
//  - Everything else (FSM, counters, shift register, parity accumulator) stays inline.
// TESTING (CLKS_PER_BIT=87, 100 ns clock; TX successor drives line unless noted)
//  1. DATA_BITS=8, PARITY=0, STOP=1. Send 8'h3F, then 8'hAB back-to-back.
//     -> two DV pulses; bytes 3F then AB; both error flags 0.
//  2. PARITY=2 (even). Send 8'h3F with parity bit forced to 1.
//     -> DV with byte 3F, o_Parity_Err=1, o_Frame_Err=0.
//     Repeat with correct parity 0 -> o_Parity_Err=0.
//  3. DATA_BITS=7, PARITY=1, STOP=2. Send 7'h55 with second stop bit driven low.
//     -> DV with byte 55, o_Frame_Err=1.
//  4. Drive line low for 30 clocks, then high.
//     -> no DV; o_RX_Active stays 0; the next valid 8'hA5 is received correctly.
//  5. Hold line low for 20 bit times.
//     -> exactly one DV with byte 00 and o_Frame_Err=1; no further DV until the line returns
//     high; the following 8'h3F is received.
//  6. Assert i_Reset for 1 clock during data bit 4 of 8'hAB.
//     -> no DV for that frame; outputs at reset values; the next 8'h3F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX and TX blocks.
//  - Parity mode encodings.
//  - Receiver FSM state type.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to 1, which matches an idle-high serial line.
//  i_clk    in  destination clock
//  i_rst    in  synchronous, active-high reset
//  i_async  in  asynchronous input
//  o_sync   out synchronised output (two clocks of latency)
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: DATA_BITS data bits (LSB first), optional
// odd/even parity, one or two stop bits. Reports parity and framing errors
// with every frame, rejects false starts and reports a line break once.
//  i_Clock       in   system clock
//  i_Reset       in   synchronous, active-high reset
//  i_RX_Serial   in   asynchronous serial line, idle high
//  o_RX_DV       out  one-cycle pulse: frame complete, outputs below valid
//  o_RX_Byte     out  received data, held until next o_RX_DV
//  o_Parity_Err  out  parity mismatch on the flagged frame
//  o_Frame_Err   out  a stop bit sampled low on the flagged frame
//  o_RX_Active   out  high from a confirmed start bit until frame completion
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_RX_Active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  logic line;

  uart_sync2 u_sync (
    .i_clk   (i_Clock),
    .i_rst   (i_Reset),
    .i_async (i_RX_Serial),
    .o_sync  (line)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 par_pend_q, par_pend_d;
  logic                 frm_pend_q, frm_pend_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 active_q, active_d;
  logic                 par_exp;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    active_d   = active_q;
    // Even parity expects the XOR of the data bits; odd expects its complement.
    par_exp    = (PARITY == PAR_EVEN) ? par_acc_q : ~par_acc_q;

    case (state_q)
      RX_IDLE: begin
        if (!line) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end

      RX_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (line) begin
            // Glitch shorter than half a bit: drop it silently.
            state_d = RX_IDLE;
          end else begin
            state_d    = RX_DATA;
            active_d   = 1'b1;
            bit_d      = '0;
            stop_d     = 1'b0;
            par_acc_d  = 1'b0;
            par_pend_d = 1'b0;
            frm_pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_DATA: begin
        if (cnt_q == CNT_END) begin
          cnt_d          = '0;
          shift_d[bit_q] = line;
          par_acc_d      = par_acc_q ^ line;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_PARITY: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = RX_STOP;
          if (line != par_exp) par_pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_STOP: begin
        if (cnt_q == CNT_END) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) begin
            // Outputs are registered, so DV appears one clock after this sample.
            dv_d     = 1'b1;
            byte_d   = shift_q;
            perr_d   = par_pend_q;
            ferr_d   = frm_pend_q | ~line;
            active_d = 1'b0;
            // A low final stop bit means a break may be in progress; wait for
            // the line to recover instead of re-triggering on the held low.
            state_d  = line ? RX_IDLE : RX_BREAK_WAIT;
          end else begin
            stop_d = 1'b1;
            if (!line) frm_pend_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_BREAK_WAIT: begin
        if (line) state_d = RX_IDLE;
      end

      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      par_pend_q <= par_pend_d;
      frm_pend_q <= frm_pend_d;
      dv_q       <= dv_d;
      byte_q     <= byte_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      active_q   <= active_d;
    end
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_RX_Active  = active_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame. Three receivers share clock and reset:
//  u0: 8N1, u1: 8 bits even parity 1 stop, u2: 7 bits odd parity 2 stop.
// Each has its own serial line; a monitor counts DV pulses and latches the
// delivered data and flags.
module tb_uart_rx_frame;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;

  logic [2:0] dv, act, pe, fe;
  logic [7:0] b0, b1;
  logic [6:0] b2;

  always #50 clk = ~clk;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx[0]), .o_RX_DV(dv[0]), .o_RX_Byte(b0),
    .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_RX_Active(act[0]));

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx[1]), .o_RX_DV(dv[1]), .o_RX_Byte(b1),
    .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_RX_Active(act[1]));

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx[2]), .o_RX_DV(dv[2]), .o_RX_Byte(b2),
    .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_RX_Active(act[2]));

  int         dv_cnt [3];
  logic [8:0] cap_b  [3];
  logic       cap_pe [3];
  logic       cap_fe [3];
  logic       act_seen;

  int n_chk  = 0;
  int n_pass = 0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      dv_cnt[i] = 0; cap_b[i] = '0; cap_pe[i] = 1'b0; cap_fe[i] = 1'b0;
    end
    act_seen = 1'b0;
  end

  always @(negedge clk) begin
    if (dv[0]) begin dv_cnt[0]++; cap_b[0] = {1'b0, b0}; cap_pe[0] = pe[0]; cap_fe[0] = fe[0]; end
    if (dv[1]) begin dv_cnt[1]++; cap_b[1] = {1'b0, b1}; cap_pe[1] = pe[1]; cap_fe[1] = fe[1]; end
    if (dv[2]) begin dv_cnt[2]++; cap_b[2] = {2'b0, b2}; cap_pe[2] = pe[2]; cap_fe[2] = fe[2]; end
    if (act[0]) act_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input int idx, input logic b);
    rx[idx] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
    #1;
  endtask

  // start bit, nbits data LSB first, optional parity bit, nstop stop bits
  // (stop_v[k] is the level driven for stop bit k)
  task automatic send(input int idx, input logic [8:0] d, input int nbits, input bit has_par,
                      input logic pbit, input int nstop, input logic [1:0] stop_v);
    drive_bit(idx, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(idx, d[i]);
    if (has_par) drive_bit(idx, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(idx, stop_v[i]);
    rx[idx] = 1'b1;
    #1;
  endtask

  int base;

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_dv", {31'b0, dv[0]}, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_byte", {24'b0, b0}, 0);
    chk("rst_flags", {28'b0, pe[0], fe[0], act[0], dv[0]}, 0);
    chk("rst_byte7", {25'b0, b2}, 0);
    repeat (5) @(negedge clk);

    // 1: back-to-back 8N1 frames
    send(0, 9'h3F, 8, 0, 1'b0, 1, 2'b11);
    chk("t1_cnt_a", dv_cnt[0], 1);
    chk("t1_byte_a", cap_b[0], 9'h3F);
    send(0, 9'hAB, 8, 0, 1'b0, 1, 2'b11);
    wait_bits(1);
    chk("t1_cnt_b", dv_cnt[0], 2);
    chk("t1_byte_b", cap_b[0], 9'hAB);
    chk("t1_flags", {cap_pe[0], cap_fe[0]}, 0);

    // 2: even parity; 3F has six ones so the correct parity bit is 0
    send(1, 9'h3F, 8, 1, 1'b1, 1, 2'b11);
    wait_bits(1);
    chk("t2_cnt_bad", dv_cnt[1], 1);
    chk("t2_byte_bad", cap_b[1], 9'h3F);
    chk("t2_perr_bad", cap_pe[1], 1);
    chk("t2_ferr_bad", cap_fe[1], 0);
    send(1, 9'h3F, 8, 1, 1'b0, 1, 2'b11);
    wait_bits(1);
    chk("t2_cnt_ok", dv_cnt[1], 2);
    chk("t2_perr_ok", cap_pe[1], 0);

    // 3: 7 bits odd parity 2 stop; 55 has four ones -> parity bit 1; stop 2 low
    send(2, 9'h55, 7, 1, 1'b1, 2, 2'b01);
    wait_bits(1);
    chk("t3_cnt", dv_cnt[2], 1);
    chk("t3_byte", cap_b[2], 9'h55);
    chk("t3_ferr", cap_fe[2], 1);
    chk("t3_perr", cap_pe[2], 0);

    // 4: 30-clock glitch is a false start
    base = dv_cnt[0];
    act_seen = 1'b0;
    rx[0] = 1'b0;
    repeat (30) @(negedge clk);
    rx[0] = 1'b1;
    wait_bits(2);
    chk("t4_no_dv", dv_cnt[0], base);
    chk("t4_no_act", {31'b0, act_seen}, 0);
    send(0, 9'hA5, 8, 0, 1'b0, 1, 2'b11);
    wait_bits(1);
    chk("t4_cnt", dv_cnt[0], base + 1);
    chk("t4_byte", cap_b[0], 9'hA5);

    // 5: break held for 20 bit times
    base = dv_cnt[0];
    rx[0] = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    #1;
    chk("t5_cnt", dv_cnt[0], base + 1);
    chk("t5_byte", cap_b[0], 0);
    chk("t5_ferr", cap_fe[0], 1);
    rx[0] = 1'b1;
    wait_bits(2);
    chk("t5_no_more", dv_cnt[0], base + 1);
    send(0, 9'h3F, 8, 0, 1'b0, 1, 2'b11);
    wait_bits(1);
    chk("t5_next_cnt", dv_cnt[0], base + 2);
    chk("t5_next_byte", cap_b[0], 9'h3F);
    chk("t5_next_ferr", cap_fe[0], 0);

    // 6: reset pulse during data bit 4 of AB
    base = dv_cnt[0];
    fork
      send(0, 9'hAB, 8, 0, 1'b0, 1, 2'b11);
      begin
        repeat (5 * CPB + 20) @(negedge clk);
        #1;
        chk("t6_act_pre", {31'b0, act[0]}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_byte", {24'b0, b0}, 0);
        chk("t6_rst_flags", {28'b0, pe[0], fe[0], act[0], dv[0]}, 0);
      end
    join
    chk("t6_no_dv", dv_cnt[0], base);
    // let any frame the receiver locked onto mid-byte drain before resending
    wait_bits(15);
    send(0, 9'h3F, 8, 0, 1'b0, 1, 2'b11);
    wait_bits(1);
    chk("t6_next_byte", cap_b[0], 9'h3F);
    chk("t6_next_flags", {cap_pe[0], cap_fe[0]}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
